seq_detect_arbiter: RTL and testbench

- Shares one 2-bit sequence-detector next-state datapath among N_CH serial bit streams.
- Each channel keeps its own 2-bit state context. A round-robin arbiter grants at most one channel per cycle; the granted bit advances that channel's context.
- A registered result (hit flag, channel, new state) is produced one cycle later.
- Sits between the serial input sources and downstream event logic, replacing per-channel detector instances.

---
 rtl/seq_detect_arbiter.sv | 117 +++++++++++
 tb/tb_seq_detect_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_arbiter.sv
// Round-robin shared sequence detector: N_CH serial streams time-share one
// "three or more consecutive ones" next-state datapath. Each stream keeps its own 2-bit context.
module seq_detect_arbiter #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CH_W  = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [N_CH-1:0]  ch_clear,
   input  logic [N_CH-1:0]  req_valid,
   input  logic [N_CH-1:0]  req_bit,
   output logic [N_CH-1:0]  req_ready,
   output logic             out_valid,
   output logic [CH_W-1:0]  out_ch,
   output logic             out_hit,
   output logic [1:0]       out_state,
   output logic [CNT_W-1:0] hit_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ONE  = 2'd1,
      S_TWO  = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   state_t            ctx     [N_CH];
   state_t            ctx_nxt [N_CH];
   logic [CH_W-1:0]   rr_last;
   logic [CH_W-1:0]   gnt_idx;
   logic [CH_W-1:0]   cand;
   logic              gnt_any;
   logic [N_CH-1:0]   eligible;
   state_t            sel_state;
   logic              sel_bit;
   state_t            dp_next;
   logic              dp_hit;

   // Round-robin search starting after the last granted channel; never looks at req_bit
   always_comb begin
      eligible  = req_valid & ~ch_clear & {N_CH{enable}};
      req_ready = '0;
      gnt_idx   = '0;
      gnt_any   = 1'b0;
      cand      = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         cand = CH_W'((32'(rr_last) + k) % N_CH);
         if (!gnt_any && eligible[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   // Shared next-state/hit datapath, fed by the granted channel's context and bit
   always_comb begin
      sel_state = ctx[gnt_idx];
      sel_bit   = req_bit[gnt_idx];
      dp_next   = S_IDLE;
      unique case (sel_state)
         S_IDLE:  dp_next = sel_bit ? S_ONE : S_IDLE;
         S_ONE:   dp_next = sel_bit ? S_TWO : S_IDLE;
         S_TWO:   dp_next = sel_bit ? S_RUN : S_IDLE;
         S_RUN:   dp_next = sel_bit ? S_RUN : S_IDLE;
         default: dp_next = S_IDLE;
      endcase
      dp_hit = sel_bit & ((sel_state == S_TWO) | (sel_state == S_RUN));
   end

   // Per-channel context next state: clear wins, otherwise only the granted channel advances
   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         ctx_nxt[i] = ctx[i];
         if (ch_clear[i]) begin
            ctx_nxt[i] = S_IDLE;
         end else if (gnt_any && (gnt_idx == CH_W'(i))) begin
            ctx_nxt[i] = dp_next;
         end
      end
   end

   // Context register file
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < N_CH; i++) ctx[i] <= S_IDLE;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) ctx[i] <= ctx_nxt[i];
      end
   end

   // Arbiter pointer, registered result and saturating hit counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_last   <= CH_W'(N_CH - 1);
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_hit   <= 1'b0;
         out_state <= 2'd0;
         hit_count <= '0;
      end else if (gnt_any) begin
         rr_last   <= gnt_idx;
         out_valid <= 1'b1;
         out_ch    <= gnt_idx;
         out_hit   <= dp_hit;
         out_state <= dp_next;
         if (dp_hit && (hit_count != {CNT_W{1'b1}})) begin
            hit_count <= hit_count + CNT_W'(1);
         end
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed bench for seq_detect_arbiter (4 channels, 4-bit hit counter).
module tb_seq_detect_arbiter;

   localparam int unsigned N_CH  = 4;
   localparam int unsigned CH_W  = 2;
   localparam int unsigned CNT_W = 4;

   logic             clock;
   logic             reset_n;
   logic             enable;
   logic [N_CH-1:0]  ch_clear;
   logic [N_CH-1:0]  req_valid;
   logic [N_CH-1:0]  req_bit;
   logic [N_CH-1:0]  req_ready;
   logic             out_valid;
   logic [CH_W-1:0]  out_ch;
   logic             out_hit;
   logic [1:0]       out_state;
   logic [CNT_W-1:0] hit_count;

   int total = 0;
   int bad   = 0;

   seq_detect_arbiter #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .enable    (enable),
      .ch_clear  (ch_clear),
      .req_valid (req_valid),
      .req_bit   (req_bit),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .out_hit   (out_hit),
      .out_state (out_state),
      .hit_count (hit_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c, input logic e);
      req_valid = v;
      req_bit   = b;
      ch_clear  = c;
      enable    = e;
   endtask

   task automatic chk_out(input string tag, input logic v, input int ch, input int st, input logic h);
      chk({tag, "_valid"}, 32'(out_valid), 32'(v));
      chk({tag, "_ch"},    32'(out_ch),    32'(ch));
      chk({tag, "_state"}, 32'(out_state), 32'(st));
      chk({tag, "_hit"},   32'(out_hit),   32'(h));
   endtask

   int exp_s [6] = '{1, 2, 3, 3, 0, 1};
   int exp_h [6] = '{0, 0, 1, 1, 0, 0};
   logic [5:0] bits6 = 6'b111101;
   int rr_order [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
   int exp_cnt;

   initial begin
      // reset and idle
      reset_n = 1'b0;
      drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick(); tick(); tick();
      chk_out("rst", 1'b0, 0, 0, 1'b0);
      chk("rst_cnt", 32'(hit_count), 32'd0);
      reset_n = 1'b1;
      enable  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1 chk("idle_ready", 32'(req_ready), 32'd0);
         tick();
         chk("idle_valid", 32'(out_valid), 32'd0);
         chk("idle_cnt", 32'(hit_count), 32'd0);
      end

      // single channel 1,1,1,1,0,1 on ch0
      for (int i = 0; i < 6; i++) begin
         drive(4'b0001, {3'b000, bits6[5-i]}, 4'b0000, 1'b1);
         #1 chk("single_ready", 32'(req_ready), 32'b0001);
         tick();
         chk_out("single", 1'b1, 0, exp_s[i], exp_h[i][0]);
      end
      drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
      tick();
      chk("single_idle_valid", 32'(out_valid), 32'd0);
      chk("single_hold_state", 32'(out_state), 32'd1);
      chk("single_cnt", 32'(hit_count), 32'd2);

      // clear all contexts, then full load round robin (last grant was ch0)
      drive(4'b0000, 4'b0000, 4'b1111, 1'b1);
      #1 chk("clrall_ready", 32'(req_ready), 32'd0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(4'b1111, 4'b1111, 4'b0000, 1'b1);
         #1 chk("rr_ready", 32'(req_ready), 32'(1) << rr_order[i]);
         tick();
         chk_out("rr", 1'b1, rr_order[i], (i < 4) ? 1 : 2, 1'b0);
      end
      chk("rr_cnt", 32'(hit_count), 32'd2);

      // sparse: ch2 granted, then ch0 and ch2 compete
      drive(4'b0100, 4'b0000, 4'b0000, 1'b1);
      #1 chk("sparse_ready0", 32'(req_ready), 32'b0100);
      tick();
      chk_out("sparse0", 1'b1, 2, 0, 1'b0);
      drive(4'b0101, 4'b0000, 4'b0000, 1'b1);
      #1 chk("sparse_ready1", 32'(req_ready), 32'b0001);
      tick();
      chk_out("sparse1", 1'b1, 0, 0, 1'b0);
      #1 chk("sparse_ready2", 32'(req_ready), 32'b0100);
      tick();
      chk_out("sparse2", 1'b1, 2, 0, 1'b0);

      // clear priority on ch1 (in s2); ch3 (in s2) still granted
      drive(4'b1010, 4'b1010, 4'b0010, 1'b1);
      #1 chk("clr_ready", 32'(req_ready), 32'b1000);
      tick();
      chk_out("clr_ch3", 1'b1, 3, 3, 1'b1);
      chk("clr_cnt", 32'(hit_count), 32'd3);
      drive(4'b0010, 4'b0010, 4'b0000, 1'b1);
      #1 chk("clr_ready1", 32'(req_ready), 32'b0010);
      tick();
      chk_out("clr_ch1", 1'b1, 1, 1, 1'b0);

      // saturation: ch3 in s3, each further 1 hits
      exp_cnt = 3;
      for (int i = 0; i < 20; i++) begin
         drive(4'b1000, 4'b1000, 4'b0000, 1'b1);
         #1 chk("sat_ready", 32'(req_ready), 32'b1000);
         tick();
         exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
         chk("sat_cnt", 32'(hit_count), 32'(exp_cnt));
      end
      chk("sat_hit", 32'(out_hit), 32'd1);

      // enable drop mid-stream on ch0 (ctx0 = s0)
      drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
      #1 chk("en_ready0", 32'(req_ready), 32'b0001);
      tick();
      chk_out("en_last", 1'b1, 0, 1, 1'b0);
      drive(4'b0001, 4'b0001, 4'b0000, 1'b0);
      for (int i = 0; i < 2; i++) begin
         #1 chk("en_off_ready", 32'(req_ready), 32'd0);
         tick();
         chk_out("en_off", 1'b0, 0, 1, 1'b0);
         chk("en_off_cnt", 32'(hit_count), 32'd15);
      end
      drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
      #1 chk("en_on_ready", 32'(req_ready), 32'b0001);
      tick();
      chk_out("en_resume0", 1'b1, 0, 2, 1'b0);
      #1 chk("en_on_ready1", 32'(req_ready), 32'b0001);
      tick();
      chk_out("en_resume1", 1'b1, 0, 3, 1'b1);
      chk("en_sat_cnt", 32'(hit_count), 32'd15);

      // asynchronous reset mid-operation
      reset_n = 1'b0;
      #1;
      chk_out("mid_rst", 1'b0, 0, 0, 1'b0);
      chk("mid_rst_cnt", 32'(hit_count), 32'd0);
      tick();
      reset_n = 1'b1;
      drive(4'b0011, 4'b0011, 4'b0000, 1'b1);
      #1 chk("post_rst_ready0", 32'(req_ready), 32'b0001);
      tick();
      chk_out("post_rst0", 1'b1, 0, 1, 1'b0);
      #1 chk("post_rst_ready1", 32'(req_ready), 32'b0010);
      tick();
      chk_out("post_rst1", 1'b1, 1, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
